adc_sample_ctrl: RTL

Periodic acquisition scheduler between the I2C master driving the PCF8591 ADC and the LCD1602 display driver. On each sample tick it issues a burst of single-byte read requests to the I2C master, averages the codes and scales the average to volts×100 (e.g. 330 = 3.30 V). It then publishes the value on the 16-bit `voltage` bus consumed by the LCD driver. Bus timeouts and read errors are detected and reported without corrupting the displayed value.

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_code_to_volt.sv | 36 +++
 rtl/adc_sample_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and scaling constants for the ADC acquisition scheduler.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_REQ,
        ST_CONVERT,
        ST_PUBLISH
    } adc_state_t;

    localparam int VOLT_W      = 16;
    localparam int PROD_W      = 34;
    localparam int SCALE_MUL   = 257;
    localparam int SCALE_RND   = 32768;
    localparam int SCALE_SHIFT = 16;

endpackage

// File: rtl/adc_code_to_volt.sv
// One-cycle registered scaler: 8-bit average ADC code to volts x100.
module adc_code_to_volt
    import adc_pkg::*;
#(
    parameter int VREF_X100 = 330
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p0,
    input  logic [7:0]        avg_p0,
    output logic              vld_p1,
    output logic [VOLT_W-1:0] volt_p1
);

    // code*257/65536 approximates code/255, so full-scale code lands on VREF_X100
    function automatic logic [VOLT_W-1:0] scale_round(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] rounded;
        rounded = (prod + PROD_W'(SCALE_RND)) >> SCALE_SHIFT;
        return rounded[VOLT_W-1:0];
    endfunction

    logic [PROD_W-1:0] prod_p0;

    assign prod_p0 = PROD_W'(avg_p0) * PROD_W'(VREF_X100) * PROD_W'(SCALE_MUL);

    // p0 -> p1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) volt_p1 <= scale_round(prod_p0);
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic PCF8591 sampling: burst of I2C reads per tick, average, scale, publish to LCD.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 5_000_000,
    parameter int AVG_LOG2      = 2,
    parameter int VREF_X100     = 330,
    parameter int TIMEOUT       = 1_000_000,
    parameter int ADC_CH        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              rd_req,
    output logic [1:0]        rd_ch,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [7:0]        rd_data,
    output logic [VOLT_W-1:0] voltage,
    output logic              volt_valid,
    output logic              busy,
    output logic              err_flag
);

    localparam int NREADS = 1 << AVG_LOG2;
    localparam int SUM_W  = 8 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int TICK_W = $clog2(SAMPLE_PERIOD);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    adc_state_t        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  sum;
    logic [7:0]        avg;
    logic              tick_wrap;
    logic              burst_start;
    logic              waiting;
    logic              take_err;
    logic              take_ack;
    logic              take_to;
    logic              last_read;
    logic              scl_vld;
    logic [VOLT_W-1:0] scl_volt;

    assign rd_ch       = 2'(ADC_CH);
    assign tick_wrap   = (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));
    assign burst_start = (state == ST_WAIT_TICK) && enable && tick_wrap;
    assign waiting     = (state == ST_REQ) && rd_req;
    assign take_err    = waiting && rd_err;
    assign take_ack    = waiting && rd_ack && !rd_err;
    assign take_to     = waiting && !rd_ack && !rd_err && (to_cnt == TO_W'(TIMEOUT - 1));
    assign last_read   = (cnt == CNT_W'(NREADS - 1));
    assign avg         = 8'(sum >> AVG_LOG2);

    // Tick phase is free-running outside IDLE so burst starts stay on a fixed grid
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               tick_cnt <= '0;
        else if (state == ST_IDLE || tick_wrap) tick_cnt <= '0;
        else                                   tick_cnt <= tick_cnt + TICK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (burst_start)   sum <= '0;
        else if (take_ack) sum <= sum + SUM_W'(rd_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_req     <= 1'b0;
            to_cnt     <= '0;
            cnt        <= '0;
            voltage    <= '0;
            volt_valid <= 1'b0;
            busy       <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            volt_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (tick_wrap) begin
                        state  <= ST_REQ;
                        rd_req <= 1'b1;
                        to_cnt <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // rd_req low inside REQ is the one-cycle gap between reads
                    if (!rd_req) begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            rd_req <= 1'b1;
                            to_cnt <= '0;
                        end
                    end else if (take_err || take_to) begin
                        rd_req   <= 1'b0;
                        err_flag <= 1'b1;
                        busy     <= 1'b0;
                        state    <= enable ? ST_WAIT_TICK : ST_IDLE;
                    end else if (take_ack) begin
                        rd_req <= 1'b0;
                        cnt    <= cnt + CNT_W'(1);
                        if (!enable) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (last_read) begin
                            state <= ST_CONVERT;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_CONVERT: begin
                    state <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    if (scl_vld) begin
                        voltage    <= scl_volt;
                        volt_valid <= 1'b1;
                        err_flag   <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= ST_WAIT_TICK;
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    adc_code_to_volt #(
        .VREF_X100(VREF_X100)
    ) u_scale (
        .clk    (clk),
        .rst    (rst),
        .vld_p0 (state == ST_CONVERT),
        .avg_p0 (avg),
        .vld_p1 (scl_vld),
        .volt_p1(scl_volt)
    );

endmodule
